// File: rtl/sh_mac_iter.sv
// Iterative multiply/accumulate unit owning MACH/MACL: retires RADIX multiplier bits per cycle,
// with a BUSY interlock, a DONE pulse and MAC.L/MAC.W saturation.
module sh_mac_iter #(
  parameter int unsigned W     = 32,
  parameter int unsigned RADIX = 8,
  parameter int unsigned SATW  = 48
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ce,
  input  logic         i_req,
  input  logic [3:0]   i_op,
  input  logic [1:0]   i_sel,
  input  logic         i_sat,
  input  logic [W-1:0] i_a_di,
  input  logic [W-1:0] i_b_di,
  output logic [W-1:0] o_do,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned N   = W / RADIX;
  localparam int unsigned W2  = 2 * W;
  localparam int unsigned HW  = W / 2;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SHW = $clog2(W2) + 1;

  localparam logic [3:0] OpLds    = 4'b0000;
  localparam logic [3:0] OpMulL   = 4'b0001;
  localparam logic [3:0] OpDmulu  = 4'b0010;
  localparam logic [3:0] OpDmuls  = 4'b0011;
  localparam logic [3:0] OpMuluW  = 4'b0110;
  localparam logic [3:0] OpMulsW  = 4'b0111;
  localparam logic [3:0] OpMacL   = 4'b1001;
  localparam logic [3:0] OpMacW   = 4'b1011;
  localparam logic [3:0] OpClrmac = 4'b1111;

  // Signed saturation bounds for MAC.L, one bit wider than the accumulator.
  localparam logic [W2:0] SatHi = {{(W2 + 2 - SATW){1'b0}}, {(SATW - 1){1'b1}}};
  localparam logic [W2:0] SatLo = {{(W2 + 2 - SATW){1'b1}}, {(SATW - 1){1'b0}}};
  localparam logic [W-1:0] WordMax = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] WordMin = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMult, StFin} state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a_mag;
  logic [W-1:0]    r_b_sh;
  logic            r_neg;
  logic [3:0]      r_op;
  logic            r_sat;
  logic [W2-1:0]   r_part;
  logic [W-1:0]    r_mach;
  logic [W-1:0]    r_macl;
  logic            r_busy;
  logic            r_done;

  logic            w_is_mul;
  logic            w_half;
  logic            w_signed;
  logic [W-1:0]    w_a_ext;
  logic [W-1:0]    w_b_ext;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic [RADIX-1:0]   w_digit;
  logic [W+RADIX-1:0] w_prod;
  logic [SHW-1:0]  w_shamt;
  logic [W2-1:0]   w_add;
  logic [W2-1:0]   w_p;
  logic [W2-1:0]   w_acc;
  logic [W2-1:0]   w_sum;
  logic [W2:0]     w_sum_x;
  logic [W2-1:0]   w_sat_l;
  logic [W:0]      w_sw;
  logic            w_sw_ovf;
  logic [W-1:0]    w_mach_nx;
  logic [W-1:0]    w_macl_nx;

  always_comb begin
    w_is_mul = 1'b0;
    w_half   = 1'b0;
    w_signed = 1'b0;
    case (i_op)
      OpMulL:  w_is_mul = 1'b1;
      OpDmulu: w_is_mul = 1'b1;
      OpDmuls: begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OpMuluW: begin w_is_mul = 1'b1; w_half = 1'b1; end
      OpMulsW: begin w_is_mul = 1'b1; w_half = 1'b1; w_signed = 1'b1; end
      OpMacL:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OpMacW:  begin w_is_mul = 1'b1; w_half = 1'b1; w_signed = 1'b1; end
      default: ;
    endcase
  end

  assign w_a_ext = w_half ? {{HW{w_signed & i_a_di[HW-1]}}, i_a_di[HW-1:0]} : i_a_di;
  assign w_b_ext = w_half ? {{HW{w_signed & i_b_di[HW-1]}}, i_b_di[HW-1:0]} : i_b_di;
  assign w_a_neg = w_signed & w_a_ext[W-1];
  assign w_b_neg = w_signed & w_b_ext[W-1];
  // The most negative value maps to 2^(W-1), which still fits as an unsigned magnitude.
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_digit = r_b_sh[RADIX-1:0];
  assign w_prod  = {{RADIX{1'b0}}, r_a_mag} * {{W{1'b0}}, w_digit};
  assign w_shamt = SHW'(r_cnt) * SHW'(RADIX);
  assign w_add   = W2'(w_prod) << w_shamt;

  assign w_p     = r_neg ? -r_part : r_part;
  assign w_acc   = {r_mach, r_macl};
  assign w_sum   = w_acc + w_p;
  assign w_sum_x = {w_acc[W2-1], w_acc} + {w_p[W2-1], w_p};

  always_comb begin
    w_sat_l = w_sum_x[W2-1:0];
    if ($signed(w_sum_x) > $signed(SatHi)) begin
      w_sat_l = SatHi[W2-1:0];
    end else if ($signed(w_sum_x) < $signed(SatLo)) begin
      w_sat_l = SatLo[W2-1:0];
    end
  end

  // A MAC.W product is bounded by 2^(W-2), so its low W+1 bits are an exact signed value.
  assign w_sw     = {r_macl[W-1], r_macl} + w_p[W:0];
  assign w_sw_ovf = w_sw[W] ^ w_sw[W-1];

  always_comb begin
    w_mach_nx = r_mach;
    w_macl_nx = r_macl;
    case (r_op)
      OpMulL, OpMuluW, OpMulsW: w_macl_nx = w_p[W-1:0];
      OpDmulu, OpDmuls:         {w_mach_nx, w_macl_nx} = w_p;
      OpMacL: begin
        if (r_sat) {w_mach_nx, w_macl_nx} = w_sat_l;
        else       {w_mach_nx, w_macl_nx} = w_sum;
      end
      OpMacW: begin
        if (!r_sat) begin
          {w_mach_nx, w_macl_nx} = w_sum;
        end else if (w_sw_ovf) begin
          w_macl_nx = w_sw[W] ? WordMin : WordMax;
          w_mach_nx = W'(1);
        end else begin
          w_macl_nx = w_sw[W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_a_mag <= '0;
      r_b_sh  <= '0;
      r_neg   <= 1'b0;
      r_op    <= '0;
      r_sat   <= 1'b0;
      r_part  <= '0;
      r_mach  <= '0;
      r_macl  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_ce) begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_req) begin
            if (w_is_mul) begin
              r_state <= StMult;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_part  <= '0;
              r_a_mag <= w_a_mag;
              r_b_sh  <= w_b_mag;
              r_neg   <= w_a_neg ^ w_b_neg;
              r_op    <= i_op;
              r_sat   <= i_sat;
            end else if (i_op == OpLds) begin
              if (i_sel[0]) r_macl <= i_a_di;
              if (i_sel[1]) r_mach <= i_a_di;
            end else if (i_op == OpClrmac) begin
              r_mach <= '0;
              r_macl <= '0;
            end
          end
        end
        StMult: begin
          r_part <= r_part + w_add;
          r_b_sh <= r_b_sh >> RADIX;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) r_state <= StFin;
        end
        StFin: begin
          r_mach  <= w_mach_nx;
          r_macl  <= w_macl_nx;
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_do   = i_sel[1] ? r_mach : r_macl;
  assign o_busy = r_busy;
  // A stalled cycle never shows DONE; the pulse waits for the next enabled cycle.
  assign o_done = r_done & i_ce;

endmodule

// File: tb/tb_sh_mac_iter.sv
// Self-checking bench for sh_mac_iter: W=32/RADIX=8 and W=16/RADIX=4 instances run in lockstep
// against an arithmetic reference model, plus directed tables and multi-cycle corner cases.
module tb_sh_mac_iter;

  localparam logic [3:0] OpLds    = 4'b0000;
  localparam logic [3:0] OpMulL   = 4'b0001;
  localparam logic [3:0] OpDmulu  = 4'b0010;
  localparam logic [3:0] OpDmuls  = 4'b0011;
  localparam logic [3:0] OpMuluW  = 4'b0110;
  localparam logic [3:0] OpMulsW  = 4'b0111;
  localparam logic [3:0] OpMacL   = 4'b1001;
  localparam logic [3:0] OpMacW   = 4'b1011;
  localparam logic [3:0] OpClrmac = 4'b1111;

  logic        clk = 1'b0;
  logic        rst, ce, req, sat;
  logic [3:0]  op;
  logic [1:0]  sel;
  logic [31:0] a, b;
  logic [31:0] do0;
  logic [15:0] do1;
  logic        busy0, done0, busy1, done1;

  sh_mac_iter #(.W(32), .RADIX(8), .SATW(48)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_req(req), .i_op(op), .i_sel(sel), .i_sat(sat),
    .i_a_di(a), .i_b_di(b), .o_do(do0), .o_busy(busy0), .o_done(done0)
  );

  sh_mac_iter #(.W(16), .RADIX(4), .SATW(24)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_req(req), .i_op(op), .i_sel(sel), .i_sat(sat),
    .i_a_di(a[15:0]), .i_b_di(b[15:0]), .o_do(do1), .o_busy(busy1), .o_done(done1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mh [2];
  logic [63:0] ml [2];

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sel;
    logic        sat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_mul(input logic [3:0] o);
    return o inside {OpMulL, OpDmulu, OpDmuls, OpMuluW, OpMulsW, OpMacL, OpMacW};
  endfunction

  function automatic logic signed [127:0] sx(input logic [127:0] v, input int bits,
                                             input logic sgn);
    logic [127:0] m;
    logic signed [127:0] r;
    m = (128'd1 << bits) - 128'd1;
    r = $signed(v & m);
    if (sgn && v[bits-1]) r = r - $signed(128'd1 << bits);
    return r;
  endfunction

  // Returns {MACH, MACL} after one command, from plain integer arithmetic.
  function automatic logic [127:0] model_step(input logic [3:0] o, input logic [1:0] s_sel,
      input logic s_sat, input logic [63:0] av, input logic [63:0] bv, input logic [63:0] h,
      input logic [63:0] l, input int w, input int satw);
    logic [127:0] mw, m2w, acc, res;
    logic signed [127:0] ea, eb, p, s, lim;
    logic [63:0] nh, nl;
    logic use_res;
    int bits;
    logic sgn;
    mw  = (128'd1 << w) - 128'd1;
    m2w = (128'd1 << (2 * w)) - 128'd1;
    nh  = h;
    nl  = l;
    use_res = 1'b0;
    res = '0;
    acc  = ({64'd0, h} << w) | {64'd0, l};
    bits = (o inside {OpMuluW, OpMulsW, OpMacW}) ? w / 2 : w;
    sgn  = o inside {OpMulsW, OpDmuls, OpMacL, OpMacW};
    ea = sx({64'd0, av}, bits, sgn);
    eb = sx({64'd0, bv}, bits, sgn);
    p  = ea * eb;
    case (o)
      OpLds: begin
        if (s_sel[0]) nl = av & mw[63:0];
        if (s_sel[1]) nh = av & mw[63:0];
      end
      OpClrmac: begin nh = '0; nl = '0; end
      OpMulL, OpMuluW, OpMulsW: nl = 64'($unsigned(p) & mw);
      OpDmulu, OpDmuls: begin res = $unsigned(p) & m2w; use_res = 1'b1; end
      OpMacL, OpMacW: begin
        if (!s_sat) begin
          res = (acc + $unsigned(p)) & m2w;
          use_res = 1'b1;
        end else if (o == OpMacL) begin
          s   = sx(acc, 2 * w, 1'b1) + p;
          lim = $signed(128'd1 << (satw - 1));
          if (s > lim - 1) s = lim - 1;
          else if (s < -lim) s = -lim;
          res = $unsigned(s) & m2w;
          use_res = 1'b1;
        end else begin
          s   = sx({64'd0, l}, w, 1'b1) + p;
          lim = $signed(128'd1 << (w - 1));
          if (s > lim - 1) begin
            nl = 64'(lim - 1);
            nh = 64'd1;
          end else if (s < -lim) begin
            nl = 64'($unsigned(lim));
            nh = 64'd1;
          end else begin
            nl = 64'($unsigned(s) & mw);
          end
        end
      end
      default: ;
    endcase
    if (use_res) begin
      nh = 64'(res >> w);
      nl = 64'(res & mw);
    end
    return {nh, nl};
  endfunction

  task automatic model_apply(input logic [3:0] o, input logic [1:0] s_sel, input logic s_sat,
                             input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < 2; i++) begin
      {mh[i], ml[i]} = model_step(o, s_sel, s_sat, {32'd0, av}, {32'd0, bv}, mh[i], ml[i],
                                  (i == 0) ? 32 : 16, (i == 0) ? 48 : 24);
    end
  endtask

  task automatic check_regs(input string tag);
    sel = 2'b01;
    #1;
    check({tag, " w32 MACL"}, 64'(do0), ml[0]);
    check({tag, " w16 MACL"}, 64'(do1), ml[1]);
    sel = 2'b10;
    #1;
    check({tag, " w32 MACH"}, 64'(do0), mh[0]);
    check({tag, " w16 MACH"}, 64'(do1), mh[1]);
  endtask

  // Issues one command at a negedge; returns at the negedge where results are visible.
  task automatic issue(input logic [3:0] o, input logic [1:0] s_sel, input logic s_sat,
                       input logic [31:0] av, input logic [31:0] bv, input string tag);
    int nb0, nb1;
    @(negedge clk);
    req = 1'b1; op = o; sel = s_sel; sat = s_sat; a = av; b = bv;
    @(negedge clk);
    req = 1'b0;
    model_apply(o, s_sel, s_sat, av, bv);
    if (is_mul(o)) begin
      nb0 = 0;
      nb1 = 0;
      while ((busy0 || busy1) && nb0 < 20) begin
        if (busy0) nb0++;
        if (busy1) nb1++;
        @(negedge clk);
      end
      check({tag, " w32 busy width"}, 64'(nb0), 64'd5);
      check({tag, " w16 busy width"}, 64'(nb1), 64'd5);
      check({tag, " w32 done"}, 64'(done0), 64'd1);
      check({tag, " w16 done"}, 64'(done1), 64'd1);
      check_regs(tag);
      @(negedge clk);
      check({tag, " w32 done single"}, 64'(done0), 64'd0);
    end else begin
      check({tag, " w32 no busy"}, 64'(busy0), 64'd0);
      check({tag, " w32 no done"}, 64'(done0), 64'd0);
      check_regs(tag);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_l;
    logic [31:0] pool [6];
    logic [3:0]  ops [12];
    int i;

    tbl.push_back('{OpLds,   2'b11, 1'b0, 32'h11112222, 32'h0, 32'h11112222, 32'h11112222});
    tbl.push_back('{OpMulsW, 2'b01, 1'b0, 32'h0000FFFE, 32'h3, 32'h11112222, 32'hFFFFFFFA});
    tbl.push_back('{OpDmuls, 2'b01, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
    tbl.push_back('{OpDmulu, 2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1});
    tbl.push_back('{OpLds,   2'b01, 1'b0, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h7FFFFFFF});
    tbl.push_back('{OpLds,   2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 32'h7FFFFFFF});
    tbl.push_back('{OpMacW,  2'b01, 1'b1, 32'h1, 32'h1, 32'h1, 32'h7FFFFFFF});
    tbl.push_back('{OpMacW,  2'b01, 1'b0, 32'h1, 32'h1, 32'h1, 32'h80000000});
    tbl.push_back('{OpLds,   2'b10, 1'b0, 32'h00007FFF, 32'h0, 32'h00007FFF, 32'h80000000});
    tbl.push_back('{OpLds,   2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h00007FFF, 32'hFFFFFFFF});
    tbl.push_back('{OpMacL,  2'b01, 1'b1, 32'h1, 32'h1, 32'h00007FFF, 32'hFFFFFFFF});
    tbl.push_back('{OpMacL,  2'b01, 1'b0, 32'h1, 32'h1, 32'h00008000, 32'h0});
    tbl.push_back('{OpClrmac, 2'b01, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
    tbl.push_back('{4'b0100, 2'b11, 1'b0, 32'h5, 32'h5, 32'h0, 32'h0});
    tbl.push_back('{OpMuluW, 2'b01, 1'b0, 32'h1234FFFF, 32'h2, 32'h0, 32'h0001FFFE});
    tbl.push_back('{OpMacL,  2'b01, 1'b1, 32'h80000000, 32'h80000000, 32'h00007FFF, 32'hFFFFFFFF});
    tbl.push_back('{OpMacL,  2'b01, 1'b1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFF8000, 32'h0});
    tbl.push_back('{OpMulL,  2'b01, 1'b0, 32'hFFFFFFFF, 32'h2, 32'hFFFF8000, 32'hFFFFFFFE});
    tbl.push_back('{OpMacW,  2'b01, 1'b1, 32'h00008000, 32'h1, 32'hFFFF8000, 32'hFFFF7FFE});
    tbl.push_back('{OpMacW,  2'b01, 1'b1, 32'h00008000, 32'h00008000, 32'hFFFF8000, 32'h3FFF7FFE});
    tbl.push_back('{OpLds,   2'b01, 1'b0, 32'h80000000, 32'h0, 32'hFFFF8000, 32'h80000000});
    tbl.push_back('{OpMacW,  2'b01, 1'b1, 32'h00008000, 32'h1, 32'h1, 32'h80000000});
    tbl.push_back('{OpMacW,  2'b01, 1'b0, 32'h0000FFFF, 32'h3, 32'h1, 32'h7FFFFFFD});

    rst = 1'b1; ce = 1'b1; req = 1'b0; op = '0; sel = 2'b01; sat = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 2; k++) begin mh[k] = '0; ml[k] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(busy0), 64'd0);
    check("reset done", 64'(done0), 64'd0);
    check_regs("reset");

    foreach (tbl[k]) begin
      issue(tbl[k].op, tbl[k].sel, tbl[k].sat, tbl[k].a, tbl[k].b, $sformatf("vec%0d", k));
      sel = 2'b01;
      #1;
      check($sformatf("vec%0d table MACL", k), 64'(do0), 64'(tbl[k].el));
      sel = 2'b10;
      #1;
      check($sformatf("vec%0d table MACH", k), 64'(do0), 64'(tbl[k].eh));
    end

    // Commands held during BUSY are dropped and CE stalls stretch BUSY one cycle each.
    issue(OpLds, 2'b11, 1'b0, 32'h00C0FFEE, 32'h0, "pre-stall");
    old_l = ml[0][31:0];
    @(negedge clk);
    req = 1'b1; op = OpDmulu; sel = 2'b01; a = 32'd3; b = 32'd5;
    @(negedge clk);
    model_apply(OpDmulu, 2'b01, 1'b0, 32'd3, 32'd5);
    i = 0;
    while (busy0 && i < 30) begin
      check($sformatf("stall DO stale %0d", i), 64'(do0), 64'(old_l));
      ce  = !(i == 1 || i == 2);
      req = (i < 4);
      op  = (i < 3) ? OpLds : OpClrmac;
      a   = 32'h1234;
      i++;
      @(negedge clk);
    end
    req = 1'b0;
    ce  = 1'b1;
    #1;
    check("stall busy width", 64'(i), 64'd7);
    check("stall done", 64'(done0), 64'd1);
    check_regs("stall result");

    // Reset during the second MULT cycle aborts without a DONE.
    issue(OpLds, 2'b11, 1'b0, 32'hDEADBEEF, 32'h0, "pre-abort");
    @(negedge clk);
    req = 1'b1; op = OpMulL; a = 32'd9; b = 32'd9;
    @(negedge clk);
    req = 1'b0;
    check("abort busy up", 64'(busy0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin mh[k] = '0; ml[k] = '0; end
    check("abort busy w32", 64'(busy0), 64'd0);
    check("abort busy w16", 64'(busy1), 64'd0);
    check("abort done", 64'(done0), 64'd0);
    check_regs("abort");
    repeat (6) begin
      @(negedge clk);
      check("abort no late done", 64'(done0 | done1), 64'd0);
    end
    issue(OpMulL, 2'b01, 1'b0, 32'd7, 32'd6, "after abort");
    sel = 2'b01;
    #1;
    check("after abort 42", 64'(do0), 64'd42);

    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFFFFFF;
    pool[3] = 32'h80000000; pool[4] = 32'h7FFFFFFF; pool[5] = 32'h00008000;
    ops = '{OpLds, OpMulL, OpDmulu, OpDmuls, OpMuluW, OpMulsW, OpMacL, OpMacW, OpClrmac,
            4'b0101, 4'b1000, 4'b1100};
    for (int k = 0; k < 150; k++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      issue(ops[$urandom_range(0, 11)], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ra, rb, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
